dmem_responder: RTL and testbench

- Responder (memory-side) end of the load/store interface that the datapath issues on MemRead/MemWrite.
- Word-organised data RAM behind a valid/ready request channel and a valid/ready response channel, with programmable wait states.
- Replaces the zero-latency data memory when the datapath is moved to a stall-capable, handshake-driven memory port.

---
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind valid/ready request and response channels, with programmable wait states.
// Optional byte-lane store strobes via DMEM_BYTE_EN_EN.
module dmem_responder #(
   parameter int AW          = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_EN_EN
   input  logic [3:0]  req_be,
`endif
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 2 ** AW;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

   logic [1:0]    state_reg;
   logic [3:0]    cnt_reg;
   logic          we_reg;
   logic [31:0]   addr_reg;
   logic [31:0]   wdata_reg;
   logic [3:0]    be_eff;
   logic          accept;
   logic          commit;
   logic          addr_err;
   logic [AW-1:0] idx;
   logic [31:0]   rd_word;

   assign accept   = req_valid & req_ready;
   assign commit   = (state_reg == WAIT) && (cnt_reg == 4'd0);
   assign addr_err = (addr_reg[1:0] != 2'b00) | (addr_reg[31:AW+2] != '0);
   assign idx      = addr_reg[AW+1:2];

`ifdef DMEM_BYTE_EN_EN
   logic [3:0] be_reg;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         be_reg <= 4'h0;
      else if (state_reg == IDLE && accept)
         be_reg <= req_be;
   end
   assign be_eff = be_reg;
`else
   assign be_eff = 4'hF;
`endif

   // The accept edge counts as one cycle, so WAIT is entered with the full
   // WAIT_STATES count and latency comes out as WAIT_STATES+1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         cnt_reg    <= 4'd0;
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
         we_reg     <= 1'b0;
         addr_reg   <= 32'h0;
         wdata_reg  <= 32'h0;
      end else begin
         case (state_reg)
            IDLE: begin
               req_ready <= ~accept;
               if (accept) begin
                  we_reg    <= req_we;
                  addr_reg  <= req_addr;
                  wdata_reg <= req_wdata;
                  cnt_reg   <= WS_INIT;
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_reg == 4'd0) begin
                  state_reg  <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= addr_err;
                  resp_rdata <= (!we_reg && !addr_err) ? rd_word : 32'h0;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   // One byte-wide array per lane keeps strobed stores a plain write enable.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_lane [DEPTH];
         always_ff @(posedge clk) begin
            if (commit && we_reg && !addr_err && be_eff[gi])
               mem_lane[idx] <= wdata_reg[8*gi +: 8];
         end
         assign rd_word[8*gi +: 8] = mem_lane[idx];
      end
   endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 uses WAIT_STATES=2, instance 1 uses WAIT_STATES=0.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid  [2];
   logic        req_ready  [2];
   logic        req_we     [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic [3:0]  req_be     [2];
   logic        resp_valid [2];
   logic        resp_ready [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_responder #(.AW(8), .WAIT_STATES(2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef DMEM_BYTE_EN_EN
      .req_be(req_be[0]),
`endif
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
   );

   dmem_responder #(.AW(8), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef DMEM_BYTE_EN_EN
      .req_be(req_be[1]),
`endif
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Present a request, wait (bounded) for req_ready, return just after the accept edge.
   task automatic issue(input int d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      int n;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_be[d]    = be;
      req_valid[d] = 1'b1;
      n = 0;
      @(negedge clk);
      while (req_ready[d] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) check("issue_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      $display("req  dut%0d we=%0b addr=0x%08h wdata=0x%08h be=%b", d, we, addr, wdata, be);
   endtask

   // Wait for the response, check latency/data/err, hold it for 'hold' cycles, then handshake.
   task automatic finish_resp(input int d, input int hold, input int exp_lat,
                              input logic [31:0] exp_rdata, input logic exp_err, input string tag);
      int k;
      logic [31:0] rd;
      resp_ready[d] = (hold == 0);
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (resp_valid[d] !== 1'b1 && k < 40);
      check({tag, "_lat"}, 32'(k), 32'(exp_lat));
      check({tag, "_rdata"}, resp_rdata[d], exp_rdata);
      check({tag, "_err"}, {31'd0, resp_err[d]}, {31'd0, exp_err});
      rd = resp_rdata[d];
      $display("resp dut%0d %s lat=%0d rdata=0x%08h err=%0b", d, tag, k, rd, resp_err[d]);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_valid"}, {31'd0, resp_valid[d]}, 32'd1);
         check({tag, "_hold_rdata"}, resp_rdata[d], rd);
         check({tag, "_hold_rdy"}, {31'd0, req_ready[d]}, 32'd0);
      end
      resp_ready[d] = 1'b1;
      @(posedge clk);
      #1;
      resp_ready[d] = 1'b0;
      check({tag, "_post_valid"}, {31'd0, resp_valid[d]}, 32'd0);
      check({tag, "_post_err"}, {31'd0, resp_err[d]}, 32'd0);
      check({tag, "_post_rdy0"}, {31'd0, req_ready[d]}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_post_rdy1"}, {31'd0, req_ready[d]}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'h0;
         req_wdata[d] = 32'h0; req_be[d] = 4'hF; resp_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
      check("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
      check("rst_resp_rdata", resp_rdata[0], 32'h0);
      check("rst_resp_err", {31'd0, resp_err[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rdy_after_rst", {31'd0, req_ready[0]}, 32'd1);

      // Basic store/load with WAIT_STATES=2
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      finish_resp(0, 0, 3, 32'h0, 1'b0, "st10");
      issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
      finish_resp(0, 0, 3, 32'hDEADBEEF, 1'b0, "ld10");

      // Misaligned and out-of-range loads
      issue(0, 1'b0, 32'h13, 32'h0, 4'hF);
      finish_resp(0, 0, 3, 32'h0, 1'b1, "ld13");
      issue(0, 1'b0, 32'h400, 32'h0, 4'hF);
      finish_resp(0, 0, 3, 32'h0, 1'b1, "ld400");
      issue(0, 1'b1, 32'h402, 32'h55555555, 4'hF);
      finish_resp(0, 0, 3, 32'h0, 1'b1, "st402");
      issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
      finish_resp(0, 0, 3, 32'hDEADBEEF, 1'b0, "ld10b");

      // Back-pressure on the response channel
      issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
      finish_resp(0, 5, 3, 32'hDEADBEEF, 1'b0, "ld10hold");

      // Reset while a store is in WAIT: no RAM write
      issue(0, 1'b1, 32'h20, 32'h0, 4'hF);
      finish_resp(0, 0, 3, 32'h0, 1'b0, "st20zero");
      issue(0, 1'b1, 32'h20, 32'h12345678, 4'hF);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_req_ready", {31'd0, req_ready[0]}, 32'd0);
      check("midrst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
      check("midrst_resp_rdata", resp_rdata[0], 32'h0);
      check("midrst_resp_err", {31'd0, resp_err[0]}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      issue(0, 1'b0, 32'h20, 32'h0, 4'hF);
      finish_resp(0, 0, 3, 32'h0, 1'b0, "ld20");

      // WAIT_STATES=0 instance: top word boundary and word 0
      issue(1, 1'b1, 32'h3FC, 32'hA5A5C3C3, 4'hF);
      finish_resp(1, 0, 1, 32'h0, 1'b0, "st3fc");
      issue(1, 1'b1, 32'h000, 32'h0BADF00D, 4'hF);
      finish_resp(1, 0, 1, 32'h0, 1'b0, "st000");
      issue(1, 1'b0, 32'h3FC, 32'h0, 4'hF);
      finish_resp(1, 0, 1, 32'hA5A5C3C3, 1'b0, "ld3fc");
      issue(1, 1'b0, 32'h000, 32'h0, 4'hF);
      finish_resp(1, 0, 1, 32'h0BADF00D, 1'b0, "ld000");

`ifdef DMEM_BYTE_EN_EN
      issue(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
      finish_resp(0, 0, 3, 32'h0, 1'b0, "st30full");
      issue(0, 1'b1, 32'h30, 32'h0000AB00, 4'b0010);
      finish_resp(0, 0, 3, 32'h0, 1'b0, "st30be");
      issue(0, 1'b1, 32'h30, 32'h00000000, 4'b0000);
      finish_resp(0, 0, 3, 32'h0, 1'b0, "st30be0");
      issue(0, 1'b0, 32'h30, 32'h0, 4'b0000);
      finish_resp(0, 0, 3, 32'hFFFFABFF, 1'b0, "ld30");
`else
      issue(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'hF);
      finish_resp(0, 0, 3, 32'h0, 1'b0, "st30full");
      issue(0, 1'b1, 32'h30, 32'h0000AB00, 4'b0010);
      finish_resp(0, 0, 3, 32'h0, 1'b0, "st30nobe");
      issue(0, 1'b0, 32'h30, 32'h0, 4'hF);
      finish_resp(0, 0, 3, 32'h0000AB00, 1'b0, "ld30");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
